scroll_idx_gen: RTL

Upstream stage of the 8x8 dot-matrix row scanner: produces the 7-bit start index `idx` that the scanner adds its 0..7 row offset to when addressing the font/pattern ROM.
Advances `idx` at a slow, parameterised scroll rate, so a message wider than 8 columns slides across the matrix.

---
 rtl/scroll_pkg.sv | 25 ++
 rtl/tick_div.sv | 35 +++
 rtl/scroll_idx_gen.sv | 133 +++++++++++++
 3 files changed

// File: rtl/scroll_pkg.sv
// scroll_pkg: shared types and constants for the scroll index generator.
//   state_t   : FSM state encoding
//   DIR_FWD / DIR_REV : meaning of the dir input
//   IDX_W     : width of the start index sent to the row scanner
`timescale 1ns/1ps
package scroll_pkg;

   localparam int IDX_W = 7;

   localparam logic DIR_FWD = 1'b0;
   localparam logic DIR_REV = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCROLL = 2'd1,
      ST_HOLD   = 2'd2,
      ST_PAUSED = 2'd3
   } state_t;

   // Where a scroll (re)starts: the left edge going forward, the right edge in reverse.
   function automatic logic [IDX_W-1:0] start_idx(input logic d, input logic [IDX_W-1:0] max_idx);
      return (d == DIR_REV) ? max_idx : '0;
   endfunction

endpackage

// File: rtl/tick_div.sv
// tick_div: scroll-rate prescaler.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   en   : count while high
//   clr  : synchronous clear (wins over en)
//   tick : one-cycle pulse in the cycle the count sits at TICK_DIV-1
`timescale 1ns/1ps
module tick_div #(
   parameter int TICK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/scroll_idx_gen.sv
// scroll_idx_gen: start-column index for the 8x8 dot-matrix row scanner.
//   clk       : system clock
//   rst       : asynchronous active-low reset
//   en        : 1 = scrolling allowed, 0 = freeze (idx held)
//   dir       : 0 = forward, 1 = reverse; sampled on each tick
//   pause_p   : one-cycle pulse, toggles pause
//   restart_p : one-cycle pulse, back to the start position for dir
//   idx       : registered start index
//   step      : one-cycle pulse in the cycle idx changes
//   at_end    : high while dwelling at the message end
//
// state  | meaning
// IDLE   | disabled, idx frozen, prescaler cleared
// SCROLL | idx moves one column per tick
// HOLD   | dwelling at the end column, counting ticks before the wrap
// PAUSED | idx frozen, prescaler cleared, remembers SCROLL or HOLD
`timescale 1ns/1ps
module scroll_idx_gen
   import scroll_pkg::*;
#(
   parameter int TICK_DIV   = 25000000,
   parameter int MSG_LEN    = 96,
   parameter int HOLD_TICKS = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             dir,
   input  logic             pause_p,
   input  logic             restart_p,
   output logic [IDX_W-1:0] idx,
   output logic             step,
   output logic             at_end
);

   localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(MSG_LEN - 8);
   localparam int HW = $clog2(HOLD_TICKS + 2);
   // Compared before incrementing, so the counter never needs to hold HOLD_TICKS.
   localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0);

   state_t        state;
   state_t        saved;
   logic [HW-1:0] hold_cnt;
   logic          tick;
   logic          cnt_en;
   logic          cnt_clr;
   logic [IDX_W-1:0] wrap_idx;

   assign cnt_en   = (state == ST_SCROLL) || (state == ST_HOLD);
   assign cnt_clr  = restart_p || !cnt_en;
   assign wrap_idx = start_idx(dir, MAX_IDX);

   tick_div #(.TICK_DIV(TICK_DIV)) u_tick_div (
      .clk  (clk),
      .rst  (rst),
      .en   (cnt_en),
      .clr  (cnt_clr),
      .tick (tick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx      <= '0;
         step     <= 1'b0;
         at_end   <= 1'b0;
         hold_cnt <= '0;
         state    <= ST_IDLE;
         saved    <= ST_SCROLL;
      end else begin
         step <= 1'b0;
         if (restart_p) begin
            idx      <= wrap_idx;
            step     <= (wrap_idx != idx);
            hold_cnt <= '0;
            at_end   <= 1'b0;
            state    <= en ? ST_SCROLL : ST_IDLE;
         end else if (!en) begin
            state  <= ST_IDLE;
            saved  <= ST_SCROLL;
            at_end <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  state <= ST_SCROLL;
               end
               ST_PAUSED: begin
                  if (pause_p) begin
                     state  <= saved;
                     at_end <= (saved == ST_HOLD);
                  end
               end
               ST_SCROLL, ST_HOLD: begin
                  if (pause_p) begin
                     saved  <= state;
                     state  <= ST_PAUSED;
                     at_end <= 1'b0;
                  end else if (tick) begin
                     if (state == ST_SCROLL) begin
                        if (dir == DIR_FWD && idx < MAX_IDX) begin
                           idx  <= idx + 1'b1;
                           step <= 1'b1;
                        end else if (dir == DIR_REV && idx != '0) begin
                           idx  <= idx - 1'b1;
                           step <= 1'b1;
                        end else if (HOLD_TICKS == 0) begin
                           idx  <= wrap_idx;
                           step <= 1'b1;
                        end else begin
                           state    <= ST_HOLD;
                           hold_cnt <= '0;
                           at_end   <= 1'b1;
                        end
                     end else if (hold_cnt == HOLD_LAST) begin
                        // Wrap target follows dir as it is at wrap time.
                        idx      <= wrap_idx;
                        step     <= 1'b1;
                        hold_cnt <= '0;
                        state    <= ST_SCROLL;
                        at_end   <= 1'b0;
                     end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                     end
                  end
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule
